// File: rtl/vigna_pkg.sv
// vigna_pkg: shared state, grant and mode encodings for the vigna memory arbiter.
package vigna_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_IBUSY = 2'd1,
      ARB_DBUSY = 2'd2
   } arb_state_t;
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR = 1;
endpackage

// File: rtl/vigna_arb_pick.sv
// vigna_arb_pick: combinational 2-way picker; mode=1 hands a tie to the port not granted last.
module vigna_arb_pick
   import vigna_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   input  logic mode,
   output logic gnt_valid,
   output logic gnt_sel
);
   assign gnt_valid = req_i | req_d;
   assign gnt_sel = (req_i & req_d) ? (mode ? ~last_grant : GNT_D) : (req_d ? GNT_D : GNT_I);
endmodule

// File: rtl/vigna_mem_arbiter.sv
// vigna_mem_arbiter: merges instruction and data ports onto one valid/ready memory port,
// with an optional watchdog that aborts hung transactions and records a sticky bus error.
module vigna_mem_arbiter
   import vigna_pkg::*;
#(
   parameter int ARB_MODE = 1,
   parameter int TIMEOUT  = 256
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] m_rdata,
   output logic        bus_err,
   output logic [31:0] bus_err_addr
);
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t    r_state, w_next;
   logic          r_m_valid, r_last, r_bus_err;
   logic [31:0]   r_m_addr, r_m_wdata, r_bus_err_addr;
   logic [3:0]    r_m_wstrb;
   logic [TW-1:0] r_timer;
   logic          w_gnt_valid, w_gnt_sel, w_busy, w_expire, w_done, w_grant;

   vigna_arb_pick u_pick (
      .req_i      (i_valid),
      .req_d      (d_valid),
      .last_grant (r_last),
      .mode       (ARB_MODE == ARB_RR),
      .gnt_valid  (w_gnt_valid),
      .gnt_sel    (w_gnt_sel)
   );

   assign w_busy   = r_state != ARB_IDLE;
   assign w_grant  = !w_busy && w_gnt_valid;
   // Ready on the expiry cycle wins over the abort.
   assign w_expire = (TIMEOUT > 0) && w_busy && !m_ready && r_timer == TMAX;
   assign w_done   = w_busy && (m_ready || w_expire);

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ARB_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = !w_busy ? (w_gnt_valid ? (w_gnt_sel == GNT_D ? ARB_DBUSY : ARB_IBUSY) : ARB_IDLE)
                       : (w_done ? ARB_IDLE : r_state);
   end

   always_comb begin
      i_ready = (r_state == ARB_IBUSY) && (m_ready || w_expire);
      d_ready = (r_state == ARB_DBUSY) && (m_ready || w_expire);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_m_valid      <= 1'b0;
         r_m_addr       <= '0;
         r_m_wdata      <= '0;
         r_m_wstrb      <= '0;
         r_last         <= GNT_I;
         r_timer        <= '0;
         r_bus_err      <= 1'b0;
         r_bus_err_addr <= '0;
      end else if (w_grant) begin
         r_m_valid <= 1'b1;
         r_m_addr  <= (w_gnt_sel == GNT_D) ? d_addr : i_addr;
         r_m_wdata <= (w_gnt_sel == GNT_D) ? d_wdata : '0;
         r_m_wstrb <= (w_gnt_sel == GNT_D) ? d_wstrb : '0;
         r_last    <= w_gnt_sel;
         r_timer   <= '0;
      end else if (w_done) begin
         r_m_valid <= 1'b0;
         if (w_expire) begin
            r_bus_err <= 1'b1;
            if (!r_bus_err) r_bus_err_addr <= r_m_addr;
         end
      end else if (w_busy) begin
         r_timer <= r_timer + TW'(1);
      end
   end

   assign m_valid      = r_m_valid;
   assign m_addr       = r_m_addr;
   assign m_wdata      = r_m_wdata;
   assign m_wstrb      = r_m_wstrb;
   assign bus_err      = r_bus_err;
   assign bus_err_addr = r_bus_err_addr;
   assign i_rdata      = m_rdata;
   assign d_rdata      = m_rdata;
endmodule

// File: tb/tb_vigna_mem_arbiter.sv
// tb_vigna_mem_arbiter: directed bench; u0 is fixed-priority, u1 round-robin, both TIMEOUT=8 on shared inputs.
module tb_vigna_mem_arbiter;
   import vigna_pkg::*;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        i_valid = 1'b0, d_valid = 1'b0, m_ready = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
   logic [3:0]  d_wstrb = '0;

   logic        a_i_ready, a_d_ready, a_m_valid, a_bus_err;
   logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_bus_err_addr;
   logic [3:0]  a_m_wstrb;
   logic        b_i_ready, b_d_ready, b_m_valid, b_bus_err;
   logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_bus_err_addr;
   logic [3:0]  b_m_wstrb;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   vigna_mem_arbiter #(.ARB_MODE(ARB_FIXED), .TIMEOUT(8)) u0 (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(a_i_ready), .i_addr(i_addr), .i_rdata(a_i_rdata),
      .d_valid(d_valid), .d_ready(a_d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(a_d_rdata),
      .m_valid(a_m_valid), .m_ready(m_ready), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
      .m_wstrb(a_m_wstrb), .m_rdata(m_rdata),
      .bus_err(a_bus_err), .bus_err_addr(a_bus_err_addr)
   );

   vigna_mem_arbiter #(.ARB_MODE(ARB_RR), .TIMEOUT(8)) u1 (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(b_i_ready), .i_addr(i_addr), .i_rdata(b_i_rdata),
      .d_valid(d_valid), .d_ready(b_d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(b_d_rdata),
      .m_valid(b_m_valid), .m_ready(m_ready), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
      .m_wstrb(b_m_wstrb), .m_rdata(m_rdata),
      .bus_err(b_bus_err), .bus_err_addr(b_bus_err_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   // Starts a data read in an IDLE cycle and never answers until BUSY cycle 8, where rdy_last decides.
   task automatic run_timeout(input logic [31:0] addr, input logic rdy_last);
      cyc;
      d_valid = 1'b1; d_addr = addr; d_wstrb = 4'h0;
      for (int b = 1; b <= 8; b++) begin
         cyc;
         m_ready = (b == 8) ? rdy_last : 1'b0;
         mid;
         if (b == 1) chk("to_m_addr", a_m_addr, addr);
         if (b == 7) chk("to_no_early_dready", a_d_ready, 1'b0);
         if (b == 8) begin
            chk("to_dready_c8", a_d_ready, 1'b1);
            chk("to_mvalid_c8", a_m_valid, 1'b1);
            chk("to_rr_dready_c8", b_d_ready, 1'b1);
         end
      end
   endtask

   initial begin
      cyc; cyc;
      mid;
      chk("rst_m_valid", a_m_valid, 1'b0);
      chk("rst_m_addr", a_m_addr, 32'h0);
      chk("rst_bus_err", a_bus_err, 1'b0);
      chk("rst_bus_err_addr", a_bus_err_addr, 32'h0);
      chk("rst_rr_m_valid", b_m_valid, 1'b0);

      // single instruction read answered on the third BUSY cycle
      cyc;
      resetn = 1'b1; i_valid = 1'b1; i_addr = 32'h100;
      mid;
      chk("rd_idle_mvalid", a_m_valid, 1'b0);
      cyc;
      mid;
      chk("rd_mvalid", a_m_valid, 1'b1);
      chk("rd_maddr", a_m_addr, 32'h100);
      chk("rd_mwstrb", a_m_wstrb, 4'h0);
      chk("rd_iready_early", a_i_ready, 1'b0);
      cyc;
      mid;
      cyc;
      m_ready = 1'b1; m_rdata = 32'h13;
      mid;
      chk("rd_iready", a_i_ready, 1'b1);
      chk("rd_irdata", a_i_rdata, 32'h13);
      chk("rd_dready", a_d_ready, 1'b0);
      cyc;
      i_valid = 1'b0; m_ready = 1'b0;
      mid;
      chk("rd_idle_after", a_m_valid, 1'b0);
      chk("rd_iready_once", a_i_ready, 1'b0);

      // simultaneous requests: data store first, instruction after a bubble
      cyc;
      i_valid = 1'b1; i_addr = 32'h4;
      d_valid = 1'b1; d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = 32'hDEADBEEF;
      cyc;
      m_ready = 1'b1; m_rdata = 32'h55;
      mid;
      chk("fx_maddr_d", a_m_addr, 32'h2000);
      chk("fx_mwdata_d", a_m_wdata, 32'hDEADBEEF);
      chk("fx_mwstrb_d", a_m_wstrb, 4'hF);
      chk("fx_dready", a_d_ready, 1'b1);
      chk("fx_iready0", a_i_ready, 1'b0);
      chk("fx_drdata", a_d_rdata, 32'h55);
      cyc;
      d_valid = 1'b0; m_ready = 1'b0;
      mid;
      chk("fx_bubble", a_m_valid, 1'b0);
      cyc;
      m_ready = 1'b1;
      mid;
      chk("fx_maddr_i", a_m_addr, 32'h4);
      chk("fx_mwdata_i", a_m_wdata, 32'h0);
      chk("fx_mwstrb_i", a_m_wstrb, 4'h0);
      chk("fx_iready", a_i_ready, 1'b1);
      chk("fx_dready0", a_d_ready, 1'b0);
      cyc;
      i_valid = 1'b0; m_ready = 1'b0;

      // both ports requesting continuously: u1 alternates D,I,..., u0 keeps granting D
      cyc;
      i_valid = 1'b1; i_addr = 32'h40;
      d_valid = 1'b1; d_addr = 32'h80; d_wstrb = 4'h0;
      for (int k = 0; k < 6; k++) begin
         cyc;
         m_ready = 1'b1;
         mid;
         chk("rr_maddr", b_m_addr, (k % 2 == 0) ? 32'h80 : 32'h40);
         chk("rr_dready", b_d_ready, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk("rr_iready", b_i_ready, (k % 2 == 0) ? 1'b0 : 1'b1);
         chk("fx_cont_maddr", a_m_addr, 32'h80);
         chk("fx_cont_iready", a_i_ready, 1'b0);
         cyc;
         m_ready = 1'b0;
      end
      i_valid = 1'b0; d_valid = 1'b0;

      // watchdog abort, twice; only the first address is logged
      run_timeout(32'h3000, 1'b0);
      cyc;
      d_valid = 1'b0; m_ready = 1'b0;
      mid;
      chk("to1_mvalid", a_m_valid, 1'b0);
      chk("to1_bus_err", a_bus_err, 1'b1);
      chk("to1_err_addr", a_bus_err_addr, 32'h3000);
      run_timeout(32'h4000, 1'b0);
      cyc;
      d_valid = 1'b0; m_ready = 1'b0;
      mid;
      chk("to2_bus_err", a_bus_err, 1'b1);
      chk("to2_err_addr", a_bus_err_addr, 32'h3000);
      chk("to2_rr_err_addr", b_bus_err_addr, 32'h3000);

      // reset while D_BUSY drops the transaction silently
      cyc;
      d_valid = 1'b1; d_addr = 32'h5000;
      cyc;
      cyc;
      resetn = 1'b0; d_valid = 1'b0;
      mid;
      chk("rs_dready_busy", a_d_ready, 1'b0);
      cyc;
      mid;
      chk("rs_mvalid", a_m_valid, 1'b0);
      chk("rs_dready", a_d_ready, 1'b0);
      chk("rs_bus_err", a_bus_err, 1'b0);
      chk("rs_err_addr", a_bus_err_addr, 32'h0);
      cyc;
      resetn = 1'b1; i_valid = 1'b1; i_addr = 32'h200;
      mid;
      chk("rs_idle", a_m_valid, 1'b0);
      cyc;
      m_ready = 1'b1; m_rdata = 32'h77;
      mid;
      chk("rs_mvalid_new", a_m_valid, 1'b1);
      chk("rs_maddr_new", a_m_addr, 32'h200);
      chk("rs_iready", a_i_ready, 1'b1);
      chk("rs_dready0", a_d_ready, 1'b0);
      cyc;
      i_valid = 1'b0; m_ready = 1'b0;

      // m_ready on the expiry cycle completes normally
      run_timeout(32'h6000, 1'b1);
      cyc;
      d_valid = 1'b0; m_ready = 1'b0;
      mid;
      chk("ex_mvalid", a_m_valid, 1'b0);
      chk("ex_bus_err", a_bus_err, 1'b0);
      chk("ex_err_addr", a_bus_err_addr, 32'h0);
      chk("ex_rr_bus_err", b_bus_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
